// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Purpose  : Duty-cycle fade sequencer for a counter_pwm instance. Drives
//            the counter's enable/compare/period and watches its count for
//            period ends. Every 'hold' periods it steps the compare value
//            between cmp_min and cmp_max, either as one ramp up (mode 0) or
//            as continuous up/down breathing (mode 1).
// Ports    : clk50m, rst_n (sync, active-low)
//            start/stop        - one-cycle control requests
//            mode, cmp_min, cmp_max, step, hold, per_cfg - configuration,
//                                latched on an accepted start
//            cnt               - count from counter_pwm
//            pwm_en, pwm_cmp, pwm_per - counter_pwm controls
//            busy, dir, done, err     - status
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl #(
  parameter int W      = 5,
  parameter int HOLD_W = 8
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [W-1:0]      cmp_min,
  input  logic [W-1:0]      cmp_max,
  input  logic [W-1:0]      step,
  input  logic [HOLD_W-1:0] hold,
  input  logic [W-1:0]      per_cfg,
  input  logic [W-1:0]      cnt,
  output logic              pwm_en,
  output logic [W-1:0]      pwm_cmp,
  output logic [W-1:0]      pwm_per,
  output logic              busy,
  output logic              dir,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0]      c_ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] c_ONE_HOLD = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic              r_mode;
  logic [W-1:0]      r_min, r_max, r_step, r_per, r_cmp;
  logic [HOLD_W-1:0] r_hold, r_hold_cnt;
  logic              r_dir, r_err;

  logic [W-1:0]      w_cmp_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_dir_nxt, w_err_nxt, w_latch;

  // Arithmetic one bit wider than the operands so neither direction wraps.
  logic [W:0]        w_sum, w_diff;
  logic [W-1:0]      w_up_val, w_dn_val;
  logic [HOLD_W:0]   w_hold_inc;
  logic              w_period_end, w_step_now;

  assign w_sum    = {1'b0, r_cmp} + {1'b0, r_step};
  assign w_diff   = {1'b0, r_cmp} - {1'b0, r_step};
  assign w_up_val = (w_sum > {1'b0, r_max}) ? r_max : w_sum[W-1:0];
  assign w_dn_val = (w_diff[W] || (w_diff[W-1:0] < r_min)) ? r_min : w_diff[W-1:0];

  // Period ends only count while the counter is enabled, i.e. in RUN.
  assign w_period_end = (r_state == S_RUN) && (cnt == r_per);
  assign w_hold_inc   = {1'b0, r_hold_cnt} + {{HOLD_W{1'b0}}, 1'b1};
  assign w_step_now   = w_period_end && (w_hold_inc == {1'b0, r_hold});

  always_comb begin
    w_state_nxt    = r_state;
    w_cmp_nxt      = r_cmp;
    w_dir_nxt      = r_dir;
    w_hold_cnt_nxt = r_hold_cnt;
    w_err_nxt      = 1'b0;
    w_latch        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stop in the same cycle cancels the start (and any error report).
        if (start && !stop) begin
          if (cmp_min <= cmp_max) begin
            w_latch        = 1'b1;
            w_cmp_nxt      = cmp_min;
            w_dir_nxt      = 1'b0;
            w_hold_cnt_nxt = '0;
            w_state_nxt    = S_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt    = S_IDLE;
          w_cmp_nxt      = '0;
          w_dir_nxt      = 1'b0;
          w_hold_cnt_nxt = '0;
        end else if (w_step_now) begin
          w_hold_cnt_nxt = '0;
          if (!r_dir) begin
            if (r_cmp == r_max) begin
              if (!r_mode) begin
                w_state_nxt = S_DONE;
                w_cmp_nxt   = '0;
              end else begin
                w_dir_nxt = 1'b1;
                w_cmp_nxt = w_dn_val;
              end
            end else begin
              w_cmp_nxt = w_up_val;
            end
          end else begin
            if (r_cmp == r_min) begin
              w_dir_nxt = 1'b0;
              w_cmp_nxt = w_up_val;
            end else begin
              w_cmp_nxt = w_dn_val;
            end
          end
        end else if (w_period_end) begin
          w_hold_cnt_nxt = w_hold_inc[HOLD_W-1:0];
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cmp_nxt   = '0;
        w_dir_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cmp_nxt   = '0;
        w_dir_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_min      <= '0;
      r_max      <= '0;
      r_step     <= '0;
      r_hold     <= '0;
      r_per      <= '0;
      r_cmp      <= '0;
      r_hold_cnt <= '0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmp      <= w_cmp_nxt;
      r_dir      <= w_dir_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_err      <= w_err_nxt;
      if (w_latch) begin
        r_mode <= mode;
        r_min  <= cmp_min;
        r_max  <= cmp_max;
        r_per  <= per_cfg;
        // Zero step / hold are stored as 1 so the datapath never sees 0.
        r_step <= (step == '0) ? c_ONE_W : step;
        r_hold <= (hold == '0) ? c_ONE_HOLD : hold;
      end
    end
  end

  assign pwm_en  = (r_state == S_RUN);
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign pwm_cmp = r_cmp;
  assign pwm_per = r_per;
  assign dir     = r_dir;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_ctrl
// Purpose  : Self-checking bench for pwm_fade_ctrl with a behavioural
//            up-counting counter_pwm model (down tied low).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_ctrl;

  logic       clk50m = 1'b0;
  logic       rst_n;
  logic       start, stop, mode;
  logic [4:0] cmp_min, cmp_max, step, per_cfg, cnt;
  logic [7:0] hold;
  logic       pwm_en, busy, dir, done, err;
  logic [4:0] pwm_cmp, pwm_per;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always #5 clk50m = ~clk50m;

  pwm_fade_ctrl #(.W(5), .HOLD_W(8)) dut (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .cmp_min(cmp_min),
    .cmp_max(cmp_max),
    .step   (step),
    .hold   (hold),
    .per_cfg(per_cfg),
    .cnt    (cnt),
    .pwm_en (pwm_en),
    .pwm_cmp(pwm_cmp),
    .pwm_per(pwm_per),
    .busy   (busy),
    .dir    (dir),
    .done   (done),
    .err    (err)
  );

  // counter_pwm stand-in: counts 0..per while enabled, held at 0 otherwise.
  always_ff @(posedge clk50m) begin
    if (!rst_n || !pwm_en) cnt <= '0;
    else if (cnt >= pwm_per) cnt <= '0;
    else cnt <= cnt + 5'd1;
  end

  always_ff @(posedge clk50m) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  typedef struct {
    logic       mode;
    logic [4:0] mn, mx, st, per;
    logic [7:0] hd;
    int         nlev;
    logic [9:0][4:0] lev;
    logic [9:0] dirs;
    logic       exp_done;
    logic       disturb;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl[NV];

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic md, input int mn, input int mx, input int st,
                              input int hd, input int per, input int nlev, input logic ed);
    vec_t v;
    v.mode = md; v.mn = 5'(mn); v.mx = 5'(mx); v.st = 5'(st);
    v.hd = 8'(hd); v.per = 5'(per); v.nlev = nlev;
    v.lev = '0; v.dirs = '0; v.exp_done = ed; v.disturb = 1'b0;
    return v;
  endfunction

  vec_t v;
  int   heff, plen, ntr, e0, d0;

  initial begin
    // Table: levels and direction after each step, derived by hand.
    tbl[0] = mk(1'b0, 4, 12, 4, 2, 15, 3, 1'b1);
    tbl[0].lev[0] = 4; tbl[0].lev[1] = 8; tbl[0].lev[2] = 12;
    tbl[1] = mk(1'b1, 0, 31, 10, 1, 31, 10, 1'b0);
    tbl[1].lev[0] = 0;  tbl[1].lev[1] = 10; tbl[1].lev[2] = 20; tbl[1].lev[3] = 30;
    tbl[1].lev[4] = 31; tbl[1].lev[5] = 21; tbl[1].lev[6] = 11; tbl[1].lev[7] = 1;
    tbl[1].lev[8] = 0;  tbl[1].lev[9] = 10;
    tbl[1].dirs[5] = 1; tbl[1].dirs[6] = 1; tbl[1].dirs[7] = 1; tbl[1].dirs[8] = 1;
    tbl[2] = mk(1'b0, 3, 5, 0, 0, 7, 3, 1'b1);
    tbl[2].lev[0] = 3; tbl[2].lev[1] = 4; tbl[2].lev[2] = 5;
    tbl[3] = mk(1'b0, 9, 9, 2, 1, 3, 1, 1'b1);
    tbl[3].lev[0] = 9;
    tbl[4] = mk(1'b1, 6, 6, 3, 1, 3, 4, 1'b0);
    tbl[4].lev[0] = 6; tbl[4].lev[1] = 6; tbl[4].lev[2] = 6; tbl[4].lev[3] = 6;
    tbl[4].dirs[1] = 1; tbl[4].dirs[3] = 1;
    tbl[5] = mk(1'b1, 2, 7, 3, 3, 4, 6, 1'b0);
    tbl[5].lev[0] = 2; tbl[5].lev[1] = 5; tbl[5].lev[2] = 7;
    tbl[5].lev[3] = 4; tbl[5].lev[4] = 2; tbl[5].lev[5] = 5;
    tbl[5].dirs[3] = 1; tbl[5].dirs[4] = 1;
    tbl[6] = tbl[0];
    tbl[6].disturb = 1'b1;

    rst_n = 1'b0; start = 0; stop = 0; mode = 0;
    cmp_min = 0; cmp_max = 0; step = 0; hold = 0; per_cfg = 0;
    repeat (3) tick();
    chk("rst_en", int'(pwm_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmp", int'(pwm_cmp), 0);
    chk("rst_per", int'(pwm_per), 0);
    chk("rst_done_err", int'({done, err, dir}), 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < NV; t++) begin
      v = tbl[t];
      mode = v.mode; cmp_min = v.mn; cmp_max = v.mx; step = v.st;
      hold = v.hd; per_cfg = v.per;
      e0 = err_cnt; d0 = done_cnt;
      heff = (v.hd == 0) ? 1 : int'(v.hd);
      plen = heff * (int'(v.per) + 1);
      ntr  = v.exp_done ? v.nlev : v.nlev - 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_start_busy", t), int'(busy), 1);
      chk($sformatf("v%0d_start_en", t), int'(pwm_en), 1);
      chk($sformatf("v%0d_start_per", t), int'(pwm_per), int'(v.per));
      chk($sformatf("v%0d_lev0", t), int'(pwm_cmp), int'(v.lev[0]));
      chk($sformatf("v%0d_dir0", t), int'(dir), 0);
      for (int i = 1; i <= ntr; i++) begin
        for (int c = 0; c < plen - 1; c++) begin
          if (v.disturb && i == 1 && c == 3) begin
            cmp_max = 5'd3; per_cfg = 5'd2; cmp_min = 5'd20;
            step = 5'd1; hold = 8'd5; mode = 1'b1;
          end
          start = (v.disturb && i == 1 && c == 5);
          tick();
        end
        start = 1'b0;
        chk($sformatf("v%0d_hold%0d", t, i - 1), int'(pwm_cmp), int'(v.lev[i-1]));
        tick();
        if (i < v.nlev) begin
          chk($sformatf("v%0d_lev%0d", t, i), int'(pwm_cmp), int'(v.lev[i]));
          chk($sformatf("v%0d_dir%0d", t, i), int'(dir), int'(v.dirs[i]));
          chk($sformatf("v%0d_busy%0d", t, i), int'(busy), 1);
        end else begin
          chk($sformatf("v%0d_done", t), int'(done), 1);
          chk($sformatf("v%0d_done_busy", t), int'(busy), 0);
          chk($sformatf("v%0d_done_en", t), int'(pwm_en), 0);
          chk($sformatf("v%0d_done_cmp", t), int'(pwm_cmp), 0);
          tick();
          chk($sformatf("v%0d_done_1cyc", t), int'(done), 0);
          chk($sformatf("v%0d_idle_busy", t), int'(busy), 0);
        end
      end
      if (!v.exp_done) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk($sformatf("v%0d_stop_state", t), int'({busy, pwm_en, done, dir}), 0);
        chk($sformatf("v%0d_stop_cmp", t), int'(pwm_cmp), 0);
        tick();
      end
      chk($sformatf("v%0d_err_count", t), err_cnt - e0, 0);
      chk($sformatf("v%0d_done_count", t), done_cnt - d0, int'(v.exp_done));
    end

    // stop coincident with a step edge: stop wins, no done.
    mode = 1; cmp_min = 5; cmp_max = 31; step = 10; hold = 1; per_cfg = 3;
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("stopstep_cmp0", int'(pwm_cmp), 5);
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stopstep_cmp", int'(pwm_cmp), 0);
    chk("stopstep_state", int'({busy, pwm_en, done}), 0);
    tick();
    chk("stopstep_nodone", done_cnt - d0, 0);

    // start and stop together in IDLE: nothing starts.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_en_err", int'({pwm_en, err}), 0);

    // Inverted bounds: one-cycle err, stays idle.
    cmp_min = 20; cmp_max = 10; mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    tick();
    chk("err_1cyc", int'(err), 0);
    chk("err_busy2", int'(busy), 0);

    // Reset mid-run clears everything, including pwm_per.
    cmp_min = 4; cmp_max = 12; step = 4; hold = 2; per_cfg = 15; mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    chk("prerst_cmp", int'(pwm_cmp), 8);
    rst_n = 1'b0;
    tick();
    chk("midrst_state", int'({busy, pwm_en, done, err, dir}), 0);
    chk("midrst_cmp", int'(pwm_cmp), 0);
    chk("midrst_per", int'(pwm_per), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_per", int'(pwm_per), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
